// File: rtl/sprite_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : sprite_ram_sdp
// Purpose  : Simple dual-port (one write, one read) sprite RAM with per-byte
//            write enables, a registered read port (latency 1) and a
//            self-timed zero-fill sweep that runs after reset and on request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W  word width in bits, multiple of 8 in 8..64 (default 32)
//   ADDR_W  address width, depth = 2**ADDR_W words   (default 8)
// Ports
//   clk_i       single clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   clear_i     request a zero-fill sweep (honoured only when idle)
//   busy_o      high while the sweep is running
//   wr_en_i     write strobe
//   ben_i       byte enables, bit k covers data bits [8k+7:8k]
//   wr_addr_i   write address
//   wr_data_i   write data
//   rd_en_i     read strobe
//   rd_addr_i   read address
//   rd_data_o   read data, valid the cycle after an accepted read
//   rd_valid_o  read data valid
// Configuration
//   SPRITE_RAM_BYPASS_EN  when defined, a same-cycle same-address read sees
//                         the bytes being written (write-first); otherwise
//                         the read returns the old word (read-first).
// ============================================================================
module sprite_ram_sdp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clear_i,
  output logic                busy_o,
  input  logic                wr_en_i,
  input  logic [DATA_W/8-1:0] ben_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o
);

  localparam int                NB        = DATA_W / 8;
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_nxt;

  // User traffic is only accepted when idle and no clear is being requested;
  // the cycle that starts a sweep discards its write and read.
  logic              user_ok;
  logic              wr_fire;
  logic              rd_fire;

  // Storage write port, shared between the sweep and user writes.
  logic              mem_we;
  logic [NB-1:0]     mem_ben;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Sweep controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    user_ok      = 1'b0;
    case (state)
      CLEAR: begin
        // The counter rolls over to zero together with the exit to IDLE, so
        // it is already parked at zero; a new sweep reloads it explicitly.
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end else begin
          user_ok = 1'b1;
        end
      end
      default: begin
        state_nxt    = CLEAR;
        clr_addr_nxt = '0;
      end
    endcase
  end

  assign busy_o  = (state == CLEAR);
  assign wr_fire = user_ok & wr_en_i;
  assign rd_fire = user_ok & rd_en_i;

  // --------------------------------------------------------------------------
  // Storage write port
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_ben   = '0;
    mem_addr  = wr_addr_i;
    mem_wdata = wr_data_i;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_ben   = '1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we  = 1'b1;
      mem_ben = ben_i;
    end
  end

  // No reset on the array. While reset is held the controller sits in CLEAR
  // at address 0, so clock edges during reset only re-zero word 0, which the
  // following sweep zeroes anyway.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_ben[k]) begin
          mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read data selection
  // --------------------------------------------------------------------------
`ifdef SPRITE_RAM_BYPASS_EN
  logic addr_hit;
  assign addr_hit = wr_fire & (wr_addr_i == rd_addr_i);

  // Write-first: each enabled lane of a colliding write is forwarded, the
  // other lanes come from the stored word.
  for (genvar k = 0; k < NB; k++) begin : g_bypass
    assign rd_word[8*k +: 8] = (addr_hit && ben_i[k]) ? wr_data_i[8*k +: 8]
                                                      : mem[rd_addr_i][8*k +: 8];
  end
`else
  // Read-first: the array is sampled before this edge's write lands.
  assign rd_word = mem[rd_addr_i];
`endif

  // --------------------------------------------------------------------------
  // Registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_fire;
      // Data holds its last value when no read is accepted.
      if (rd_fire) begin
        rd_data_o <= rd_word;
      end
    end
  end

endmodule
`default_nettype wire
